// File: rtl/lap_stopwatch_core.sv
// lap_stopwatch_core: programmable-tick stopwatch with lap FIFO.
// Divides clk down to a tick, keeps a saturating run count and buffers
// lap entries {split, interval} in a first-word fall-through FIFO that
// the display side drains with a valid/ready handshake.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start_stop_i          pulse: run/pause toggle
//   lap_i                 pulse: record lap (RUN/SAT only)
//   clear_i               pulse: return to zero, flush FIFO (highest priority)
//   t_o, tick_o           current count, 1-cycle pulse on each increment
//   running_o, sat_o      state flags
//   lap_split_o/int_o     FIFO head, lap_valid_o / lap_ready_i handshake
//   lap_count_o           FIFO occupancy
//   lap_ovf_o             sticky: a lap was dropped on a full FIFO
module lap_stopwatch_core #(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned TICK_HZ   = 1000,
    parameter int unsigned CNT_W     = 20,
    parameter int unsigned MAX_COUNT = 999_999,
    parameter int unsigned LAP_DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start_stop_i,
    input  logic                             lap_i,
    input  logic                             clear_i,
    output logic [CNT_W-1:0]                 t_o,
    output logic                             tick_o,
    output logic                             running_o,
    output logic                             sat_o,
    output logic [CNT_W-1:0]                 lap_split_o,
    output logic [CNT_W-1:0]                 lap_int_o,
    output logic                             lap_valid_o,
    input  logic                             lap_ready_i,
    output logic [$clog2(LAP_DEPTH+1)-1:0]   lap_count_o,
    output logic                             lap_ovf_o
);

    localparam int unsigned DIV     = CLK_HZ / TICK_HZ;
    localparam int unsigned PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned PTR_W   = $clog2(LAP_DEPTH);
    localparam int unsigned OCC_W   = $clog2(LAP_DEPTH + 1);
    localparam logic [CNT_W-1:0]   MAX_C  = CNT_W'(MAX_COUNT);
    localparam logic [PRESC_W-1:0] LAST_P = PRESC_W'(DIV - 1);
    localparam logic [OCC_W-1:0]   FULL_C = OCC_W'(LAP_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_SAT} state_e;

    typedef struct packed {
        logic [CNT_W-1:0] split;
        logic [CNT_W-1:0] intv;
    } lap_t;

    state_e               state_q, state_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [CNT_W-1:0]     t_q, t_d;
    logic [CNT_W-1:0]     last_q, last_d;
    logic                 tick_q, tick_d;
    logic                 running_q, running_d;
    logic                 sat_q, sat_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]     occ_q, occ_d;
    logic                 ovf_q, ovf_d;
    lap_t                 mem_q [LAP_DEPTH];

    logic tick_c, valid_c, full_c, lap_acc_c, pop_c, wr_c, drop_c;
    lap_t entry_c;

    // Pointer advance with explicit wrap so LAP_DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(LAP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Shared decodes for the FSM and datapath.
    always_comb begin
        tick_c    = (state_q == S_RUN) && (presc_q == LAST_P);
        valid_c   = (occ_q != '0);
        full_c    = (occ_q == FULL_C);
        lap_acc_c = lap_i && !clear_i && ((state_q == S_RUN) || (state_q == S_SAT));
        pop_c     = valid_c && lap_ready_i && !clear_i;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        wr_c      = lap_acc_c && (!full_c || pop_c);
        drop_c    = lap_acc_c && full_c && !pop_c;
        entry_c.split = t_q;
        entry_c.intv  = t_q - last_q;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state; clear wins over everything, SAT is only left by clear.
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start_stop_i) state_d = S_RUN;
                S_RUN: begin
                    if (tick_c && (t_q == MAX_C)) state_d = S_SAT;
                    else if (start_stop_i)        state_d = S_PAUSE;
                end
                S_PAUSE: if (start_stop_i) state_d = S_RUN;
                S_SAT:   state_d = S_SAT;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FSM output decode, registered alongside the state.
    always_comb begin
        running_d = (state_d == S_RUN);
        sat_d     = (state_d == S_SAT);
    end

    // Prescaler, count, last split and FIFO bookkeeping next-state.
    always_comb begin
        presc_d  = presc_q;
        t_d      = t_q;
        tick_d   = 1'b0;
        last_d   = last_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        ovf_d    = ovf_q;
        if (clear_i) begin
            presc_d  = '0;
            t_d      = '0;
            last_d   = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            occ_d    = '0;
            ovf_d    = 1'b0;
        end else begin
            // Prescaler holds outside RUN so a resume keeps the tick fraction.
            if (state_q == S_RUN) presc_d = tick_c ? '0 : presc_q + PRESC_W'(1);
            if (tick_c && (t_q < MAX_C)) begin
                t_d    = t_q + CNT_W'(1);
                tick_d = 1'b1;
            end
            // Last split moves even when the entry itself is dropped.
            if (lap_acc_c) last_d = t_q;
            if (wr_c)      wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_c)     rd_ptr_d = ptr_inc(rd_ptr_q);
            if (wr_c && !pop_c)      occ_d = occ_q + OCC_W'(1);
            else if (!wr_c && pop_c) occ_d = occ_q - OCC_W'(1);
            if (drop_c) ovf_d = 1'b1;
        end
    end

    // Control and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            t_q       <= '0;
            tick_q    <= 1'b0;
            last_q    <= '0;
            running_q <= 1'b0;
            sat_q     <= 1'b0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            occ_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            t_q       <= t_d;
            tick_q    <= tick_d;
            last_q    <= last_d;
            running_q <= running_d;
            sat_q     <= sat_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            occ_q     <= occ_d;
            ovf_q     <= ovf_d;
        end
    end

    // Lap storage; contents are only observed through a valid head.
    always_ff @(posedge clk) begin
        if (wr_c) mem_q[wr_ptr_q] <= entry_c;
    end

    assign t_o         = t_q;
    assign tick_o      = tick_q;
    assign running_o   = running_q;
    assign sat_o       = sat_q;
    assign lap_valid_o = valid_c;
    assign lap_count_o = occ_q;
    assign lap_ovf_o   = ovf_q;
    assign lap_split_o = valid_c ? mem_q[rd_ptr_q].split : '0;
    assign lap_int_o   = valid_c ? mem_q[rd_ptr_q].intv  : '0;

endmodule

// File: tb/tb_lap_stopwatch_core.sv
// tb_lap_stopwatch_core: scenario tasks for lap_stopwatch_core with DIV=10,
// MAX_COUNT=15, LAP_DEPTH=4; lap entries are checked against a queue of
// expected {split, interval} pairs whenever the DUT hands one over.
module tb_lap_stopwatch_core;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned OCC_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_stop_i = 1'b0;
    logic             lap_i = 1'b0;
    logic             clear_i = 1'b0;
    logic             lap_ready_i = 1'b0;
    logic [CNT_W-1:0] t_o;
    logic             tick_o;
    logic             running_o;
    logic             sat_o;
    logic [CNT_W-1:0] lap_split_o;
    logic [CNT_W-1:0] lap_int_o;
    logic             lap_valid_o;
    logic [OCC_W-1:0] lap_count_o;
    logic             lap_ovf_o;

    lap_stopwatch_core #(
        .CLK_HZ(1000), .TICK_HZ(100), .CNT_W(CNT_W), .MAX_COUNT(15), .LAP_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_stop_i(start_stop_i), .lap_i(lap_i),
        .clear_i(clear_i), .t_o(t_o), .tick_o(tick_o), .running_o(running_o),
        .sat_o(sat_o), .lap_split_o(lap_split_o), .lap_int_o(lap_int_o),
        .lap_valid_o(lap_valid_o), .lap_ready_i(lap_ready_i),
        .lap_count_o(lap_count_o), .lap_ovf_o(lap_ovf_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned split;
        int unsigned intv;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned now = 0;
    int unsigned ticks;
    int unsigned e0;
    logic [31:0] outs;

    // Scoreboard: a head is consumed on the next posedge when valid && ready.
    always @(negedge clk) begin : sb
        exp_t e;
        if (rst_n && lap_valid_o && lap_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL lap_pop_unexpected got split %0d int %0d want none", lap_split_o, lap_int_o);
            end else begin
                e = exp_q.pop_front();
                if (lap_split_o !== CNT_W'(e.split) || lap_int_o !== CNT_W'(e.intv)) begin
                    errors++;
                    $display("FAIL lap_pop got (%0d,%0d) want (%0d,%0d)", lap_split_o, lap_int_o, e.split, e.intv);
                end
            end
        end
    end

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            now++;
            #1;
        end
    endtask

    // Hold the given pulses for exactly one sampling edge.
    task automatic pulse(input logic ss, input logic lp, input logic clr);
        start_stop_i = ss;
        lap_i        = lp;
        clear_i      = clr;
        step(1);
        start_stop_i = 1'b0;
        lap_i        = 1'b0;
        clear_i      = 1'b0;
    endtask

    // Advance so that the next pulse is sampled at edge number target.
    task automatic advance_to(input int unsigned target);
        while (now + 1 < target) step(1);
    endtask

    task automatic push_exp(input int unsigned s, input int unsigned i);
        exp_t e;
        e.split = s;
        e.intv  = i;
        exp_q.push_back(e);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(3);
        outs = {t_o, tick_o, running_o, sat_o, lap_split_o, lap_int_o, lap_valid_o, lap_count_o, lap_ovf_o};
        checks++;
        if (outs !== 32'h0) begin errors++; $display("FAIL reset_outputs got %h want 0", outs); end
        rst_n = 1'b1;
        step(2);
        checks++;
        if (running_o !== 1'b0 || t_o !== 8'd0) begin errors++; $display("FAIL idle_after_reset got run %0b t %0d want 0 0", running_o, t_o); end
    endtask

    task automatic test_count;
        pulse(1'b1, 1'b0, 1'b0);
        checks++;
        if (running_o !== 1'b1) begin errors++; $display("FAIL start_running got %0b want 1", running_o); end
        ticks = 0;
        for (int k = 1; k <= 35; k++) begin
            step(1);
            if (tick_o === 1'b1) ticks++;
            checks++;
            if (tick_o !== ((k % 10) == 0)) begin errors++; $display("FAIL tick_phase k=%0d got %0b want %0b", k, tick_o, (k % 10) == 0); end
        end
        checks++;
        if (t_o !== 8'd3) begin errors++; $display("FAIL count_35 got %0d want 3", t_o); end
        checks++;
        if (ticks != 3) begin errors++; $display("FAIL tick_total got %0d want 3", ticks); end
    endtask

    task automatic test_pause;
        step(5);
        checks++;
        if (tick_o !== 1'b1 || t_o !== 8'd4) begin errors++; $display("FAIL tick_40 got tick %0b t %0d want 1 4", tick_o, t_o); end
        step(3);
        pulse(1'b1, 1'b0, 1'b0);
        checks++;
        if (running_o !== 1'b0) begin errors++; $display("FAIL paused got run %0b want 0", running_o); end
        ticks = 0;
        for (int k = 0; k < 50; k++) begin
            step(1);
            if (tick_o === 1'b1) ticks++;
        end
        checks++;
        if (ticks != 0 || t_o !== 8'd4) begin errors++; $display("FAIL pause_hold got ticks %0d t %0d want 0 4", ticks, t_o); end
        pulse(1'b0, 1'b1, 1'b0);
        checks++;
        if (lap_valid_o !== 1'b0) begin errors++; $display("FAIL lap_in_pause got valid %0b want 0", lap_valid_o); end
        pulse(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            step(1);
            checks++;
            if (tick_o !== (k == 6)) begin errors++; $display("FAIL resume_tick k=%0d got %0b want %0b", k, tick_o, k == 6); end
        end
        checks++;
        if (t_o !== 8'd5) begin errors++; $display("FAIL resume_count got %0d want 5", t_o); end
    endtask

    task automatic test_laps;
        pulse(1'b0, 1'b0, 1'b1);
        checks++;
        if (t_o !== 8'd0 || running_o !== 1'b0 || lap_count_o !== 3'd0) begin
            errors++; $display("FAIL clear_state got t %0d run %0b cnt %0d want 0 0 0", t_o, running_o, lap_count_o);
        end
        pulse(1'b1, 1'b0, 1'b0);
        e0 = now;
        advance_to(e0 + 25); push_exp(2, 2); pulse(1'b0, 1'b1, 1'b0);
        checks++;
        if (lap_valid_o !== 1'b1) begin errors++; $display("FAIL lap_visible got %0b want 1", lap_valid_o); end
        advance_to(e0 + 55); push_exp(5, 3); pulse(1'b0, 1'b1, 1'b0);
        advance_to(e0 + 95); push_exp(9, 4); pulse(1'b0, 1'b1, 1'b0);
        checks++;
        if (lap_count_o !== 3'd3) begin errors++; $display("FAIL lap_count3 got %0d want 3", lap_count_o); end
        lap_ready_i = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1);
        lap_ready_i = 1'b0;
        checks++;
        if (exp_q.size() != 0 || lap_count_o !== 3'd0) begin
            errors++; $display("FAIL laps_drain got left %0d cnt %0d want 0 0", exp_q.size(), lap_count_o);
        end
    endtask

    task automatic test_overflow;
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        e0 = now;
        advance_to(e0 + 5);  push_exp(0, 0); pulse(1'b0, 1'b1, 1'b0);
        advance_to(e0 + 15); push_exp(1, 1); pulse(1'b0, 1'b1, 1'b0);
        advance_to(e0 + 25); push_exp(2, 1); pulse(1'b0, 1'b1, 1'b0);
        advance_to(e0 + 35); push_exp(3, 1); pulse(1'b0, 1'b1, 1'b0);
        checks++;
        if (lap_ovf_o !== 1'b0) begin errors++; $display("FAIL ovf_early got %0b want 0", lap_ovf_o); end
        advance_to(e0 + 45); pulse(1'b0, 1'b1, 1'b0);
        checks++;
        if (lap_count_o !== 3'd4 || lap_ovf_o !== 1'b1) begin
            errors++; $display("FAIL full_drop got cnt %0d ovf %0b want 4 1", lap_count_o, lap_ovf_o);
        end
        // Push and pop together on a full FIFO; interval is relative to the dropped lap at t=4.
        advance_to(e0 + 55);
        push_exp(5, 1);
        lap_ready_i = 1'b1;
        pulse(1'b0, 1'b1, 1'b0);
        lap_ready_i = 1'b0;
        checks++;
        if (lap_count_o !== 3'd4 || lap_ovf_o !== 1'b1) begin
            errors++; $display("FAIL full_push_pop got cnt %0d ovf %0b want 4 1", lap_count_o, lap_ovf_o);
        end
        lap_ready_i = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1);
        lap_ready_i = 1'b0;
        checks++;
        if (exp_q.size() != 0 || lap_count_o !== 3'd0 || lap_ovf_o !== 1'b1) begin
            errors++; $display("FAIL ovf_drain got left %0d cnt %0d ovf %0b want 0 0 1", exp_q.size(), lap_count_o, lap_ovf_o);
        end
    endtask

    task automatic test_saturate;
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        ticks = 0;
        for (int k = 0; k < 200; k++) begin
            step(1);
            if (tick_o === 1'b1) ticks++;
        end
        checks++;
        if (t_o !== 8'd15 || sat_o !== 1'b1 || running_o !== 1'b0) begin
            errors++; $display("FAIL saturate got t %0d sat %0b run %0b want 15 1 0", t_o, sat_o, running_o);
        end
        checks++;
        if (ticks != 15) begin errors++; $display("FAIL sat_ticks got %0d want 15", ticks); end
        pulse(1'b1, 1'b0, 1'b0);
        step(10);
        checks++;
        if (sat_o !== 1'b1 || running_o !== 1'b0 || t_o !== 8'd15 || tick_o !== 1'b0) begin
            errors++; $display("FAIL sat_ignore_ss got sat %0b run %0b t %0d tick %0b want 1 0 15 0", sat_o, running_o, t_o, tick_o);
        end
        push_exp(15, 15);
        pulse(1'b0, 1'b1, 1'b0);
        checks++;
        if (lap_valid_o !== 1'b1) begin errors++; $display("FAIL sat_lap got valid %0b want 1", lap_valid_o); end
        lap_ready_i = 1'b1;
        for (int i = 0; i < 5 && exp_q.size() != 0; i++) step(1);
        lap_ready_i = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL sat_drain got left %0d want 0", exp_q.size()); end
    endtask

    task automatic test_clear_priority;
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) push_exp(0, 0);
            pulse(1'b0, 1'b1, 1'b0);
        end
        step(8);
        checks++;
        if (lap_ovf_o !== 1'b1 || running_o !== 1'b1 || t_o !== 8'd1) begin
            errors++; $display("FAIL pre_clear got ovf %0b run %0b t %0d want 1 1 1", lap_ovf_o, running_o, t_o);
        end
        pulse(1'b1, 1'b1, 1'b1);
        exp_q.delete();
        outs = {t_o, tick_o, running_o, sat_o, lap_split_o, lap_int_o, lap_valid_o, lap_count_o, lap_ovf_o};
        checks++;
        if (outs !== 32'h0) begin errors++; $display("FAIL clear_priority got %h want 0", outs); end
        step(25);
        checks++;
        if (t_o !== 8'd0 || running_o !== 1'b0) begin errors++; $display("FAIL clear_stays_idle got t %0d run %0b want 0 0", t_o, running_o); end
    endtask

    task automatic test_async_reset;
        pulse(1'b1, 1'b0, 1'b0);
        step(25);
        pulse(1'b0, 1'b1, 1'b0);
        checks++;
        if (lap_valid_o !== 1'b1 || running_o !== 1'b1 || t_o !== 8'd2) begin
            errors++; $display("FAIL pre_reset got valid %0b run %0b t %0d want 1 1 2", lap_valid_o, running_o, t_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        outs = {t_o, tick_o, running_o, sat_o, lap_split_o, lap_int_o, lap_valid_o, lap_count_o, lap_ovf_o};
        checks++;
        if (outs !== 32'h0) begin errors++; $display("FAIL async_reset got %h want 0", outs); end
        exp_q.delete();
        step(2);
        rst_n = 1'b1;
        step(3);
        checks++;
        if (t_o !== 8'd0 || running_o !== 1'b0) begin errors++; $display("FAIL post_reset got t %0d run %0b want 0 0", t_o, running_o); end
    endtask

    initial begin
        test_reset();
        test_count();
        test_pause();
        test_laps();
        test_overflow();
        test_saturate();
        test_clear_priority();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
